// File: rtl/datapath_issue_ctrl.sv
// rtl/datapath_issue_ctrl.sv - command FIFO and issue/result sequencing for an external datapath
//
// Purpose: queues {A,B,opcode} commands, issues at most one per cycle onto the
// registered dp_* outputs, and captures the datapath result PIPE+1 cycles after
// issue with a one-cycle res_valid strobe. No arithmetic is done here.
//
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   in_A, in_B, in_opcode         command operands and opcode
//   in_valid / in_ready           command handshake (in_ready = FIFO not full)
//   flush                         discard queued commands; in-flight results still complete
//   dp_A, dp_B, dp_opcode         registered command presented to the datapath
//   dp_Y, dp_co                   datapath result and carry-out
//   res_Y, res_co, res_valid      captured result and its one-cycle strobe
//   busy                          FIFO non-empty or a result still in flight
//   issue_count                   16-bit wrapping pop counter, only with ISSUE_COUNT_EN
//
// Configuration macro: ISSUE_COUNT_EN
module datapath_issue_ctrl #(
  parameter int N     = 16,
  parameter int PIPE  = 0,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_A,
  input  logic [N-1:0] in_B,
  input  logic [2:0]   in_opcode,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         flush,
  output logic [N-1:0] dp_A,
  output logic [N-1:0] dp_B,
  output logic [2:0]   dp_opcode,
  input  logic [N-1:0] dp_Y,
  input  logic         dp_co,
  output logic [N-1:0] res_Y,
  output logic         res_co,
  output logic         res_valid,
  output logic         busy
`ifdef ISSUE_COUNT_EN
  ,
  output logic [15:0]  issue_count
`endif
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = AW + 1;
  localparam int SW   = PIPE + 2;
  localparam int CMDW = 2 * N + 3;

  logic [CMDW-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [SW-1:0]   r_vld;
  logic [N-1:0]    r_dp_a;
  logic [N-1:0]    r_dp_b;
  logic [2:0]      r_dp_op;
  logic [N-1:0]    r_res_y;
  logic            r_res_co;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [CMDW-1:0] w_rd_cmd;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  // in_ready looks only at the registered count, so a pop in the same cycle
  // never opens a slot early.
  assign in_ready = !w_full;
  // Flush freezes both ends of the FIFO for the cycle it is asserted.
  assign w_push   = in_valid && !w_full && !flush;
  // Pop depends on the count at the start of the cycle, so a freshly pushed
  // command is never bypassed straight through.
  assign w_pop    = !w_empty && !flush;
  assign w_rd_cmd = r_mem[r_rd_ptr];

  // Storage needs no reset: occupancy is tracked entirely by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_A, in_B, in_opcode};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_vld    <= '0;
      r_dp_a   <= '0;
      r_dp_b   <= '0;
      r_dp_op  <= '0;
      r_res_y  <= '0;
      r_res_co <= 1'b0;
    end else begin
      if (flush) begin
        r_count  <= '0;
        r_rd_ptr <= r_wr_ptr;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end

      if (w_pop) begin
        {r_dp_a, r_dp_b, r_dp_op} <= w_rd_cmd;
      end

      // Bit k set means a command issued k+1 cycles ago. Bit PIPE marks the
      // cycle the datapath result is valid; the top bit is the res_valid strobe.
      r_vld <= {r_vld[SW-2:0], w_pop};

      if (r_vld[PIPE]) begin
        r_res_y  <= dp_Y;
        r_res_co <= dp_co;
      end
    end
  end

  assign dp_A      = r_dp_a;
  assign dp_B      = r_dp_b;
  assign dp_opcode = r_dp_op;
  assign res_Y     = r_res_y;
  assign res_co    = r_res_co;
  assign res_valid = r_vld[SW-1];
  assign busy      = !w_empty || (|r_vld);

`ifdef ISSUE_COUNT_EN
  logic [15:0] r_issue_count;

  // Flush deliberately leaves the counter alone; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_issue_count <= '0;
    end else if (w_pop) begin
      r_issue_count <= r_issue_count + 16'd1;
    end
  end

  assign issue_count = r_issue_count;
`endif

endmodule

// File: tb/tb_datapath_issue_ctrl.sv
// tb/tb_datapath_issue_ctrl.sv - directed bench for datapath_issue_ctrl
module tb_datapath_issue_ctrl;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic [15:0] y;
    logic        co;
  } vec_t;

  vec_t tbl [8];

  int total = 0;
  int bad   = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [15:0] in_A;
  logic [15:0] in_B;
  logic [2:0]  in_op;
  logic        v0, v1, v2;

  logic        rdy0, rdy1, rdy2;
  logic [15:0] dpa0, dpb0, dpa1, dpb1, dpa2, dpb2;
  logic [2:0]  dpop0, dpop1, dpop2;
  logic [15:0] y0, y1, y2;
  logic        co0, co1, co2;
  logic [15:0] ry0, ry1, ry2;
  logic        rco0, rco1, rco2;
  logic        rv0, rv1, rv2;
  logic        busy0, busy1, busy2;
`ifdef ISSUE_COUNT_EN
  logic [15:0] ic0, ic1, ic2;
`endif

  always #5 clk = ~clk;

  // Stand-in datapath: 0 add, 1 and, 2 xor, anything else passes A.
  function automatic logic [16:0] dp_fn(input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] op);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a & b};
      3'd2:    return {1'b0, a ^ b};
      default: return {1'b0, a};
    endcase
  endfunction

  assign {co0, y0} = dp_fn(dpa0, dpb0, dpop0);
  assign {co2, y2} = dp_fn(dpa2, dpb2, dpop2);
  always_ff @(posedge clk) {co1, y1} <= dp_fn(dpa1, dpb1, dpop1);

  datapath_issue_ctrl #(.N(16), .PIPE(0), .DEPTH(4)) u0 (
    .clk(clk), .rst(rst), .in_A(in_A), .in_B(in_B), .in_opcode(in_op),
    .in_valid(v0), .in_ready(rdy0), .flush(flush),
    .dp_A(dpa0), .dp_B(dpb0), .dp_opcode(dpop0), .dp_Y(y0), .dp_co(co0),
    .res_Y(ry0), .res_co(rco0), .res_valid(rv0), .busy(busy0)
`ifdef ISSUE_COUNT_EN
    , .issue_count(ic0)
`endif
  );

  datapath_issue_ctrl #(.N(16), .PIPE(1), .DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .in_A(in_A), .in_B(in_B), .in_opcode(in_op),
    .in_valid(v1), .in_ready(rdy1), .flush(flush),
    .dp_A(dpa1), .dp_B(dpb1), .dp_opcode(dpop1), .dp_Y(y1), .dp_co(co1),
    .res_Y(ry1), .res_co(rco1), .res_valid(rv1), .busy(busy1)
`ifdef ISSUE_COUNT_EN
    , .issue_count(ic1)
`endif
  );

  datapath_issue_ctrl #(.N(16), .PIPE(0), .DEPTH(2)) u2 (
    .clk(clk), .rst(rst), .in_A(in_A), .in_B(in_B), .in_opcode(in_op),
    .in_valid(v2), .in_ready(rdy2), .flush(flush),
    .dp_A(dpa2), .dp_B(dpb2), .dp_opcode(dpop2), .dp_Y(y2), .dp_co(co2),
    .res_Y(ry2), .res_co(rco2), .res_valid(rv2), .busy(busy2)
`ifdef ISSUE_COUNT_EN
    , .issue_count(ic2)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k);
    in_A  = tbl[k].a;
    in_B  = tbl[k].b;
    in_op = tbl[k].op;
  endtask

  int nres;

  initial begin
    tbl[0] = '{16'd5,    16'd3,    3'd0, 16'd8,    1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 3'd0, 16'h0000, 1'b1};
    tbl[2] = '{16'h8000, 16'h8000, 3'd0, 16'h0000, 1'b1};
    tbl[3] = '{16'h00F0, 16'h0FF0, 3'd1, 16'h00F0, 1'b0};
    tbl[4] = '{16'hAAAA, 16'h5555, 3'd2, 16'hFFFF, 1'b0};
    tbl[5] = '{16'h1234, 16'hFFFF, 3'd5, 16'h1234, 1'b0};
    tbl[6] = '{16'h7FFF, 16'h0001, 3'd0, 16'h8000, 1'b0};
    tbl[7] = '{16'hBEEF, 16'h0000, 3'd3, 16'hBEEF, 1'b0};

    rst = 1'b1; flush = 1'b0; v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    in_A = '0; in_B = '0; in_op = '0;

    // Reset values
    repeat (2) next_cycle();
    @(negedge clk);
    chk("rst_dp_A", 32'(dpa0), 32'd0);
    chk("rst_dp_B", 32'(dpb0), 32'd0);
    chk("rst_dp_op", 32'(dpop0), 32'd0);
    chk("rst_res_Y", 32'(ry0), 32'd0);
    chk("rst_res_co", 32'(rco0), 32'd0);
    chk("rst_res_valid", 32'(rv0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(rdy0), 32'd1);
`ifdef ISSUE_COUNT_EN
    chk("rst_issue_count", 32'(ic0), 32'd0);
`endif
    next_cycle();

    // Table stream, PIPE=0: vector c pushed in cycle c, dp_* in c+2, result in c+3
    for (int c = 0; c < 14; c++) begin
      if (c < 8) begin
        drive(c);
        v0 = 1'b1;
      end else begin
        v0 = 1'b0;
      end
      @(negedge clk);
      if (c == 2) begin
        chk("single_dp_A", 32'(dpa0), 32'd5);
        chk("single_dp_B", 32'(dpb0), 32'd3);
        chk("single_dp_op", 32'(dpop0), 32'd0);
      end
      if (c < 8) chk("stream_in_ready", 32'(rdy0), 32'd1);
      if (c >= 3 && c < 11) begin
        chk("stream_res_valid", 32'(rv0), 32'd1);
        chk("stream_res_Y", 32'(ry0), 32'(tbl[c-3].y));
        chk("stream_res_co", 32'(rco0), 32'(tbl[c-3].co));
      end else begin
        chk("stream_res_valid_idle", 32'(rv0), 32'd0);
      end
      next_cycle();
    end
    @(negedge clk);
    chk("hold_res_Y", 32'(ry0), 32'hBEEF);
    chk("hold_dp_A", 32'(dpa0), 32'hBEEF);
    chk("drain_busy", 32'(busy0), 32'd0);
    next_cycle();

    // PIPE=1 latency: result one cycle later than PIPE=0
    for (int c = 0; c < 7; c++) begin
      if (c == 0) begin
        drive(0);
        v1 = 1'b1;
      end else begin
        v1 = 1'b0;
      end
      @(negedge clk);
      if (c == 0) chk("pipe1_in_ready", 32'(rdy1), 32'd1);
      if (c == 2) chk("pipe1_dp_A", 32'(dpa1), 32'd5);
      chk("pipe1_res_valid", 32'(rv1), (c == 4) ? 32'd1 : 32'd0);
      if (c == 4) begin
        chk("pipe1_res_Y", 32'(ry1), 32'd8);
        chk("pipe1_res_co", 32'(rco1), 32'd0);
      end
      next_cycle();
    end
    @(negedge clk);
    chk("pipe1_busy", 32'(busy1), 32'd0);
    next_cycle();

    // DEPTH=2, six consecutive offers: the issue rate keeps up, all six land in order
    for (int c = 0; c < 10; c++) begin
      if (c < 6) begin
        drive(c);
        v2 = 1'b1;
      end else begin
        v2 = 1'b0;
      end
      @(negedge clk);
      if (c < 6) chk("d2_in_ready", 32'(rdy2), 32'd1);
      if (c >= 2 && c < 8) chk("d2_dp_A", 32'(dpa2), 32'(tbl[c-2].a));
      chk("d2_res_valid", 32'(rv2), (c >= 3 && c < 9) ? 32'd1 : 32'd0);
      if (c >= 3 && c < 9) begin
        chk("d2_res_Y", 32'(ry2), 32'(tbl[c-3].y));
        chk("d2_res_co", 32'(rco2), 32'(tbl[c-3].co));
      end
      next_cycle();
    end
    @(negedge clk);
    chk("d2_busy", 32'(busy2), 32'd0);
    next_cycle();

    // Flush in the cycle after the first pop: only command 0 survives
    nres = 0;
    for (int c = 0; c < 10; c++) begin
      if (c < 4) begin
        drive(c);
        v0 = 1'b1;
      end else begin
        v0 = 1'b0;
      end
      flush = (c == 2 || c == 3);
      @(negedge clk);
      if (rv0) nres++;
      if (c == 3) chk("flush_res_Y", 32'(ry0), 32'(tbl[0].y));
      next_cycle();
    end
    flush = 1'b0;
    @(negedge clk);
    chk("flush_result_count", 32'(nres), 32'd1);
    chk("flush_busy", 32'(busy0), 32'd0);
    chk("flush_dp_A_held", 32'(dpa0), 32'(tbl[0].a));
    next_cycle();

    // Reset with two results in flight (flush asserted too; reset wins)
    for (int c = 0; c < 9; c++) begin
      if (c < 2) begin
        drive(6 + c);
        v0 = 1'b1;
      end else begin
        v0 = 1'b0;
      end
      rst   = (c == 2);
      flush = (c == 2);
      @(negedge clk);
      if (c == 2) chk("mid_busy_before_rst", 32'(busy0), 32'd1);
      if (c == 3) begin
        chk("mid_in_ready", 32'(rdy0), 32'd1);
        chk("mid_busy", 32'(busy0), 32'd0);
        chk("mid_dp_A", 32'(dpa0), 32'd0);
        chk("mid_res_Y", 32'(ry0), 32'd0);
`ifdef ISSUE_COUNT_EN
        chk("mid_issue_count", 32'(ic0), 32'd0);
`endif
      end
      if (c >= 3) chk("mid_res_valid", 32'(rv0), 32'd0);
      next_cycle();
    end
    rst = 1'b0;
    flush = 1'b0;

`ifdef ISSUE_COUNT_EN
    // Counter wrap: 65535 issues, then one more wraps to 0
    drive(0);
    v0 = 1'b1;
    for (int i = 0; i < 65535; i++) next_cycle();
    v0 = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    chk("count_65535", 32'(ic0), 32'd65535);
    next_cycle();
    v0 = 1'b1;
    next_cycle();
    v0 = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    chk("count_wrap", 32'(ic0), 32'd0);
    next_cycle();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
